regbank_port_ctrl: RTL and testbench
====================================

Name: regbank_port_ctrl

Overview:
- Client-side controller for the 32x32 two-read/one-write register bank; drives the bank's write port and both read-address ports, and captures the combinational read data.
- After reset, zero-initialises every bank entry, then serves a valid/ready request stream: optional write plus two reads per request.
- Returns each result on a registered valid/ready response channel with backpressure.
- Sits between the datapath/issue logic and the bank.

Parameters:
- ADDR_W, 5, bank address width.
- DATA_W, 32, bank data width.
- DEPTH, 32, number of bank entries; must equal 2**ADDR_W.

Ports:
- clk  in  1  system clock; all state updates on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- reqValid  in  1  request present.
- reqReady  out  1  request accepted when reqValid && reqReady.
- reqWrite  in  1  request includes a write.
- reqWrAddr  in  ADDR_W  write address.
- reqWrData  in  DATA_W  write data.
- reqRdAddrA  in  ADDR_W  read address A.
- reqRdAddrB  in  ADDR_W  read address B.
- rspValid  out  1  response present.
- rspReady  in  1  consumer accepts response.
- rspDataA  out  DATA_W  read result A.
- rspDataB  out  DATA_W  read result B.
- initDone  out  1  high once zero-init is complete.
- write  out  1  to bank write enable.
- wrAddr  out  ADDR_W  to bank write address.
- wrData  out  DATA_W  to bank write data.
- rdAddrA  out  ADDR_W  to bank read address A.
- rdDataA  in  DATA_W  from bank, combinational read A.
- rdAddrB  out  ADDR_W  to bank read address B.
- rdDataB  in  DATA_W  from bank, combinational read B.

Behaviour:
- Reset (rst_n low, async):
  - state=INIT, initCnt=0.
  - rspValid=0, rspDataA/B=0, initDone=0.
  - Bank write output forced 0 while rst_n is low.
- FSM INIT:
  - write=1, wrAddr=initCnt, wrData=0, rdAddrA/B=0, reqReady=0.
  - initCnt increments each cycle.
  - On the edge that writes entry DEPTH-1: go to RUN and set initDone=1.
  - Init takes exactly DEPTH cycles; initDone is first high DEPTH cycles after reset release.
- FSM RUN:
  - reqReady = !rspValid || rspReady (single-entry response register; no extra skid).
  - Bank ports are driven combinationally from the request: rdAddrA/B=reqRdAddrA/B, wrAddr=reqWrAddr, wrData=reqWrData.
  - write = reqValid && reqReady && reqWrite. No bank write without acceptance.
- Read semantics are write-first (same-request bypass):
  - If reqWrite and reqWrAddr==reqRdAddrA, the captured A is reqWrData; otherwise rdDataA.
  - Same rule for B, independently.
- Latency:
  - Accept at edge N makes rspValid=1 after edge N with captured data.
  - Write-only requests still produce one response; read data is valid and may be ignored.
- Response hold:
  - While rspValid && !rspReady, rspDataA/B stay stable and reqReady=0.
  - rspValid clears on rspReady unless a new request is accepted the same cycle; then it stays 1 with new data.
- Throughput: one request per cycle when rspReady is held high.
- Back-to-back: a read of an address written by the previous accepted request sees the new value, because the bank was updated at the prior edge.
- initDone stays 1 until the next reset.
- Reset mid-init: aborts the sequence; initialisation restarts from entry 0.
- Reset mid-transaction: the pending response is dropped.
- Out-of-range addresses cannot occur, since DEPTH=2**ADDR_W.

Decomposition:
- Shared package regbank_pkg holds:
  - ADDR_W and DATA_W defaults.
  - State enum {INIT, RUN}.
  - Request/response struct typedefs for later users of the bank.
- No sub-module is required. The bypass mux is inline.
- The init sequencer may be split out as regbank_init_seq if other banks need it.

Test Plan:
1. Release reset → write=1 for 32 cycles with wrAddr 0..31 and wrData=0; reqReady=0 throughout; initDone rises after cycle 32.
2. Write r5=0xDEADBEEF, then read A=5, B=0 → second response has rspDataA=0xDEADBEEF, rspDataB=0x00000000.
3. Single request: write r7=0x12345678 with reads A=7, B=7 → rspDataA=rspDataB=0x12345678 one cycle after accept.
4. rspReady=0 for 3 cycles with a response pending and reqValid=1 → reqReady=0, write=0, rspData stable; on rspReady=1, the next request is accepted the same cycle.
5. rst_n pulsed low when initCnt=10 → outputs return to reset values; init restarts at wrAddr=0 and initDone rises 32 cycles after release.
6. rspReady held 1: write r1..r4 = 1..4 back-to-back, then read pairs (1,2),(3,4) back-to-back → six responses in six consecutive cycles; reads return 1,2 then 3,4.

Source files
------------

// File: rtl/regbank_pkg.sv
// Shared definitions for the 32x32 register bank and its client-side port controllers.
package regbank_pkg;

  parameter int ADDR_W_DEF = 5;
  parameter int DATA_W_DEF = 32;

  // Port controller sequencing: zero-fill the bank, then serve requests.
  typedef enum logic {
    INIT = 1'b0,
    RUN  = 1'b1
  } regbankState_t;

  // Request as seen by a port controller: optional write plus two reads.
  typedef struct packed {
    logic                  write;
    logic [ADDR_W_DEF-1:0] wrAddr;
    logic [DATA_W_DEF-1:0] wrData;
    logic [ADDR_W_DEF-1:0] rdAddrA;
    logic [ADDR_W_DEF-1:0] rdAddrB;
  } regbankReq_t;

  // Response returned for every accepted request.
  typedef struct packed {
    logic [DATA_W_DEF-1:0] dataA;
    logic [DATA_W_DEF-1:0] dataB;
  } regbankRsp_t;

endpackage

// File: rtl/regbank_port_ctrl.sv
// Client-side controller for the two-read/one-write register bank: zero-fills
// the bank after reset, then turns a valid/ready request stream into bank
// accesses and returns read results on a registered valid/ready response.
module regbank_port_ctrl
  import regbank_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF,
  parameter int DEPTH  = 2 ** ADDR_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              reqValid,
  output logic              reqReady,
  input  logic              reqWrite,
  input  logic [ADDR_W-1:0] reqWrAddr,
  input  logic [DATA_W-1:0] reqWrData,
  input  logic [ADDR_W-1:0] reqRdAddrA,
  input  logic [ADDR_W-1:0] reqRdAddrB,
  output logic              rspValid,
  input  logic              rspReady,
  output logic [DATA_W-1:0] rspDataA,
  output logic [DATA_W-1:0] rspDataB,
  output logic              initDone,
  output logic              write,
  output logic [ADDR_W-1:0] wrAddr,
  output logic [DATA_W-1:0] wrData,
  output logic [ADDR_W-1:0] rdAddrA,
  input  logic [DATA_W-1:0] rdDataA,
  output logic [ADDR_W-1:0] rdAddrB,
  input  logic [DATA_W-1:0] rdDataB
);

  localparam logic [ADDR_W-1:0] LAST_ENTRY = ADDR_W'(DEPTH - 1);

  regbankState_t     state;
  regbankState_t     stateNext;
  logic [ADDR_W-1:0] initCnt;
  logic              accept;
  logic [DATA_W-1:0] capDataA;
  logic [DATA_W-1:0] capDataB;

  // Write-first bypass: a read of the address being written this request sees the new data.
  assign capDataA = (reqWrite && (reqWrAddr == reqRdAddrA)) ? reqWrData : rdDataA;
  assign capDataB = (reqWrite && (reqWrAddr == reqRdAddrB)) ? reqWrData : rdDataB;

  assign accept = (state == RUN) && reqValid && reqReady;

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= INIT;
    end else begin
      state <= stateNext;
    end
  end

  // Init sequencer: walk every entry once, then latch initDone until the next reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      initCnt  <= '0;
      initDone <= 1'b0;
    end else if (state == INIT) begin
      initCnt <= initCnt + 1'b1;
      if (initCnt == LAST_ENTRY) begin
        initDone <= 1'b1;
      end
    end
  end

  // Next state and bank/request-side outputs; write is held low throughout reset.
  always_comb begin
    stateNext = state;
    reqReady  = 1'b0;
    write     = 1'b0;
    wrAddr    = reqWrAddr;
    wrData    = reqWrData;
    rdAddrA   = reqRdAddrA;
    rdAddrB   = reqRdAddrB;
    unique case (state)
      INIT: begin
        write   = rst_n;
        wrAddr  = initCnt;
        wrData  = '0;
        rdAddrA = '0;
        rdAddrB = '0;
        if (initCnt == LAST_ENTRY) begin
          stateNext = RUN;
        end
      end
      RUN: begin
        reqReady = !rspValid || rspReady;
        write    = rst_n && reqValid && reqReady && reqWrite;
      end
      default: begin
        stateNext = INIT;
      end
    endcase
  end

  // Single-entry response register: load on accept, hold under backpressure, clear when consumed.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rspValid <= 1'b0;
      rspDataA <= '0;
      rspDataB <= '0;
    end else if (accept) begin
      rspValid <= 1'b1;
      rspDataA <= capDataA;
      rspDataB <= capDataB;
    end else if (rspReady) begin
      rspValid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_regbank_port_ctrl.sv
// Directed bench for regbank_port_ctrl with a behavioural 32x32 bank attached.
module tb_regbank_port_ctrl;

  localparam int ADDR_W = 5;
  localparam int DATA_W = 32;
  localparam int DEPTH  = 32;

  logic              clk;
  logic              rst_n;
  logic              reqValid;
  logic              reqReady;
  logic              reqWrite;
  logic [ADDR_W-1:0] reqWrAddr;
  logic [DATA_W-1:0] reqWrData;
  logic [ADDR_W-1:0] reqRdAddrA;
  logic [ADDR_W-1:0] reqRdAddrB;
  logic              rspValid;
  logic              rspReady;
  logic [DATA_W-1:0] rspDataA;
  logic [DATA_W-1:0] rspDataB;
  logic              initDone;
  logic              write;
  logic [ADDR_W-1:0] wrAddr;
  logic [DATA_W-1:0] wrData;
  logic [ADDR_W-1:0] rdAddrA;
  logic [DATA_W-1:0] rdDataA;
  logic [ADDR_W-1:0] rdAddrB;
  logic [DATA_W-1:0] rdDataB;

  int tests;
  int failed;

  logic [DATA_W-1:0] mem [DEPTH];

  regbank_port_ctrl #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst_n(rst_n),
    .reqValid(reqValid), .reqReady(reqReady), .reqWrite(reqWrite),
    .reqWrAddr(reqWrAddr), .reqWrData(reqWrData),
    .reqRdAddrA(reqRdAddrA), .reqRdAddrB(reqRdAddrB),
    .rspValid(rspValid), .rspReady(rspReady),
    .rspDataA(rspDataA), .rspDataB(rspDataB), .initDone(initDone),
    .write(write), .wrAddr(wrAddr), .wrData(wrData),
    .rdAddrA(rdAddrA), .rdDataA(rdDataA), .rdAddrB(rdAddrB), .rdDataB(rdDataB)
  );

  // Behavioural bank: synchronous write, combinational reads.
  always @(posedge clk) begin
    if (write) mem[wrAddr] <= wrData;
  end
  assign rdDataA = mem[rdAddrA];
  assign rdDataB = mem[rdAddrB];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic w, input logic [ADDR_W-1:0] wa,
                       input logic [DATA_W-1:0] wd, input logic [ADDR_W-1:0] ra,
                       input logic [ADDR_W-1:0] rb);
    reqValid   = v;
    reqWrite   = w;
    reqWrAddr  = wa;
    reqWrData  = wd;
    reqRdAddrA = ra;
    reqRdAddrB = rb;
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    drive(1'b0, 1'b0, '0, '0, '0, '0);
    rspReady = 1'b1;
    step();
    tests++; if (write !== 1'b0) begin failed++; $display("FAIL reset_write got=%b exp=0", write); end
    tests++; if (rspValid !== 1'b0) begin failed++; $display("FAIL reset_rspValid got=%b exp=0", rspValid); end
    tests++; if (initDone !== 1'b0) begin failed++; $display("FAIL reset_initDone got=%b exp=0", initDone); end
    tests++; if (rspDataA !== 32'h0 || rspDataB !== 32'h0) begin failed++; $display("FAIL reset_rspData got=%h/%h exp=0/0", rspDataA, rspDataB); end
    rst_n = 1'b1;
    #1;
    for (int i = 0; i < DEPTH; i++) begin
      tests++;
      if (write !== 1'b1 || wrAddr !== ADDR_W'(i) || wrData !== 32'h0 || reqReady !== 1'b0 || initDone !== 1'b0) begin
        failed++;
        $display("FAIL init_cycle%0d got write=%b wrAddr=%0d wrData=%h reqReady=%b initDone=%b exp 1/%0d/0/0/0",
                 i, write, wrAddr, wrData, reqReady, initDone, i);
      end
      step();
    end
    tests++; if (initDone !== 1'b1) begin failed++; $display("FAIL init_done got=%b exp=1", initDone); end
    tests++; if (reqReady !== 1'b1) begin failed++; $display("FAIL run_reqReady got=%b exp=1", reqReady); end
    tests++; if (write !== 1'b0) begin failed++; $display("FAIL run_idle_write got=%b exp=0", write); end
  endtask

  task automatic test_write_then_read();
    drive(1'b1, 1'b1, 5'd5, 32'hDEADBEEF, 5'd0, 5'd0);
    tests++; if (write !== 1'b1 || wrAddr !== 5'd5 || wrData !== 32'hDEADBEEF) begin failed++; $display("FAIL wr5_port got=%b/%0d/%h exp=1/5/deadbeef", write, wrAddr, wrData); end
    step();
    tests++; if (rspValid !== 1'b1) begin failed++; $display("FAIL wr5_rspValid got=%b exp=1", rspValid); end
    drive(1'b1, 1'b0, 5'd5, 32'h11111111, 5'd5, 5'd0);
    tests++; if (write !== 1'b0) begin failed++; $display("FAIL rd5_write got=%b exp=0", write); end
    step();
    tests++; if (rspValid !== 1'b1 || rspDataA !== 32'hDEADBEEF || rspDataB !== 32'h0) begin failed++; $display("FAIL rd5_data got=%b/%h/%h exp=1/deadbeef/00000000", rspValid, rspDataA, rspDataB); end
    drive(1'b0, 1'b0, '0, '0, '0, '0);
    step();
    tests++; if (rspValid !== 1'b0) begin failed++; $display("FAIL rd5_drain got=%b exp=0", rspValid); end
  endtask

  task automatic test_bypass();
    drive(1'b1, 1'b1, 5'd7, 32'h12345678, 5'd7, 5'd7);
    step();
    tests++; if (rspValid !== 1'b1 || rspDataA !== 32'h12345678 || rspDataB !== 32'h12345678) begin failed++; $display("FAIL bypass7 got=%b/%h/%h exp=1/12345678/12345678", rspValid, rspDataA, rspDataB); end
    drive(1'b0, 1'b0, '0, '0, '0, '0);
    step();
  endtask

  task automatic test_backpressure();
    rspReady = 1'b0;
    drive(1'b1, 1'b0, 5'd0, 32'h0, 5'd5, 5'd7);
    step();
    drive(1'b1, 1'b1, 5'd9, 32'hCAFEF00D, 5'd9, 5'd5);
    for (int i = 0; i < 3; i++) begin
      tests++;
      if (reqReady !== 1'b0 || write !== 1'b0 || rspValid !== 1'b1 || rspDataA !== 32'hDEADBEEF || rspDataB !== 32'h12345678) begin
        failed++;
        $display("FAIL hold_cycle%0d got reqReady=%b write=%b rspValid=%b A=%h B=%h exp 0/0/1/deadbeef/12345678",
                 i, reqReady, write, rspValid, rspDataA, rspDataB);
      end
      step();
    end
    rspReady = 1'b1;
    #1;
    tests++; if (reqReady !== 1'b1 || write !== 1'b1) begin failed++; $display("FAIL release_accept got=%b/%b exp=1/1", reqReady, write); end
    step();
    tests++; if (rspValid !== 1'b1 || rspDataA !== 32'hCAFEF00D || rspDataB !== 32'hDEADBEEF) begin failed++; $display("FAIL release_data got=%b/%h/%h exp=1/cafef00d/deadbeef", rspValid, rspDataA, rspDataB); end
    drive(1'b0, 1'b0, '0, '0, '0, '0);
    step();
    tests++; if (rspValid !== 1'b0) begin failed++; $display("FAIL release_drain got=%b exp=0", rspValid); end
  endtask

  task automatic test_back_to_back();
    logic [DATA_W-1:0] expA [6];
    logic [DATA_W-1:0] expB [6];
    logic              chk  [6];
    expA = '{32'h0, 32'h0, 32'h0, 32'h0, 32'd1, 32'd3};
    expB = '{32'h0, 32'h0, 32'h0, 32'h0, 32'd2, 32'd4};
    chk  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
    rspReady = 1'b1;
    for (int i = 0; i < 6; i++) begin
      if (i < 4) drive(1'b1, 1'b1, ADDR_W'(i + 1), DATA_W'(i + 1), 5'd20, 5'd20);
      else if (i == 4) drive(1'b1, 1'b0, 5'd0, 32'h0, 5'd1, 5'd2);
      else drive(1'b1, 1'b0, 5'd0, 32'h0, 5'd3, 5'd4);
      tests++; if (reqReady !== 1'b1) begin failed++; $display("FAIL b2b_ready%0d got=%b exp=1", i, reqReady); end
      step();
      tests++; if (rspValid !== 1'b1) begin failed++; $display("FAIL b2b_valid%0d got=%b exp=1", i, rspValid); end
      if (chk[i]) begin
        tests++;
        if (rspDataA !== expA[i] || rspDataB !== expB[i]) begin
          failed++;
          $display("FAIL b2b_data%0d got=%h/%h exp=%h/%h", i, rspDataA, rspDataB, expA[i], expB[i]);
        end
      end
    end
    drive(1'b0, 1'b0, '0, '0, '0, '0);
    step();
    tests++; if (rspValid !== 1'b0) begin failed++; $display("FAIL b2b_drain got=%b exp=0", rspValid); end
  endtask

  task automatic test_reset_mid_txn_and_init();
    rspReady = 1'b0;
    drive(1'b1, 1'b0, 5'd0, 32'h0, 5'd5, 5'd9);
    step();
    drive(1'b0, 1'b0, '0, '0, '0, '0);
    tests++; if (rspValid !== 1'b1 || rspDataA !== 32'hDEADBEEF) begin failed++; $display("FAIL pend_rsp got=%b/%h exp=1/deadbeef", rspValid, rspDataA); end
    rst_n = 1'b0;
    #1;
    tests++; if (rspValid !== 1'b0 || rspDataA !== 32'h0 || rspDataB !== 32'h0 || initDone !== 1'b0 || write !== 1'b0) begin
      failed++; $display("FAIL txn_reset got rspValid=%b A=%h B=%h initDone=%b write=%b exp 0/0/0/0/0", rspValid, rspDataA, rspDataB, initDone, write);
    end
    rspReady = 1'b1;
    step();
    rst_n = 1'b1;
    #1;
    for (int i = 0; i < 10; i++) step();
    tests++; if (wrAddr !== 5'd10 || write !== 1'b1) begin failed++; $display("FAIL init_cnt10 got=%0d/%b exp=10/1", wrAddr, write); end
    rst_n = 1'b0;
    #1;
    tests++; if (write !== 1'b0 || initDone !== 1'b0 || reqReady !== 1'b0) begin failed++; $display("FAIL midinit_reset got=%b/%b/%b exp=0/0/0", write, initDone, reqReady); end
    step();
    rst_n = 1'b1;
    #1;
    tests++; if (wrAddr !== 5'd0 || write !== 1'b1) begin failed++; $display("FAIL restart_addr got=%0d/%b exp=0/1", wrAddr, write); end
    for (int i = 0; i < DEPTH - 1; i++) step();
    tests++; if (initDone !== 1'b0 || wrAddr !== 5'd31) begin failed++; $display("FAIL restart_31 got=%b/%0d exp=0/31", initDone, wrAddr); end
    step();
    tests++; if (initDone !== 1'b1 || reqReady !== 1'b1) begin failed++; $display("FAIL restart_done got=%b/%b exp=1/1", initDone, reqReady); end
    drive(1'b1, 1'b0, 5'd0, 32'h0, 5'd5, 5'd7);
    step();
    tests++; if (rspDataA !== 32'h0 || rspDataB !== 32'h0) begin failed++; $display("FAIL rezeroed got=%h/%h exp=0/0", rspDataA, rspDataB); end
    drive(1'b0, 1'b0, '0, '0, '0, '0);
    step();
  endtask

  initial begin
    tests  = 0;
    failed = 0;
    test_reset();
    test_write_then_read();
    test_bypass();
    test_backpressure();
    test_back_to_back();
    test_reset_mid_txn_and_init();
    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
